// File: rtl/l2_arb_pkg.sv
// Shared types and address-field positions for the two-core L2 bus arbiter.
// The arbiter FSM states, the core index type, and the tag/index slice positions live here.
package l2_arb_pkg;

    localparam int ADDR_W  = 15;
    localparam int TAG_MSB = 14;
    localparam int TAG_LSB = 10;
    localparam int IDX_MSB = 9;
    localparam int IDX_LSB = 4;
    localparam int TAG_W   = TAG_MSB - TAG_LSB + 1;
    localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;

    typedef logic core_id_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SNOOP_WAIT = 3'd1,
        ST_FLUSH      = 3'd2,
        ST_GRANT      = 3'd3,
        ST_RELEASE    = 3'd4
    } arb_state_t;

    // True while some core owns the L2 port (flush or normal grant tenure).
    function automatic logic is_tenure(input arb_state_t s);
        return (s == ST_FLUSH) || (s == ST_GRANT);
    endfunction

endpackage

// File: rtl/l2_port_mux.sv
// Owner-select of one L1's request, address and write word onto the L2 port.
// force_zero parks the port at all-zero whenever no tenure is active.
module l2_port_mux
    import l2_arb_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                   sel,
    input  logic                   force_zero,
    input  logic [1:0]             core_read_request,
    input  logic [1:0]             core_write_request,
    input  logic [1:0][ADDR_W-1:0] core_word_address,
    input  logic [1:0][N-1:0]      core_write_word,
    output logic                   L2_read_request,
    output logic                   L2_write_request,
    output logic [ADDR_W-1:0]      L2_word_address,
    output logic [N-1:0]           L2_write_word
);

    always_comb begin
        L2_read_request  = 1'b0;
        L2_write_request = 1'b0;
        L2_word_address  = '0;
        L2_write_word    = '0;
        if (!force_zero) begin
            L2_read_request  = core_read_request[sel];
            L2_write_request = core_write_request[sel];
            L2_word_address  = core_word_address[sel];
            L2_write_word    = core_write_word[sel];
        end
    end

endmodule

// File: rtl/l2_bus_arbiter.sv
// Two-core L2 bus arbiter: round-robin grant, snoop broadcast to the other L1,
// and a flush tenure for a Modified holder before the original requester proceeds.
module l2_bus_arbiter
    import l2_arb_pkg::*;
#(
    parameter int n           = 32,
    parameter int SNOOP_WAIT  = 4,
    parameter int RELEASE_GAP = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   L2_busy,
    input  logic [1:0]             core_read_request,
    input  logic [1:0]             core_write_request,
    input  logic [1:0][ADDR_W-1:0] core_word_address,
    input  logic [1:0][n-1:0]      core_write_word,
    output logic                   L2_read_request,
    output logic                   L2_write_request,
    output logic [ADDR_W-1:0]      L2_word_address,
    output logic [n-1:0]           L2_write_word,
    output logic [1:0]             core_L2_busy,
    output logic [1:0]             others_read_request,
    output logic [1:0]             others_write_request,
    output logic [1:0][TAG_W-1:0]  others_block_tag,
    output logic [1:0][IDX_W-1:0]  others_block_index,
    output logic [31:0]            arb_statistics,
    output logic [2:0]             dbg_state
);

    localparam int WAIT_W = $clog2(SNOOP_WAIT + 1);
    localparam int GAP_W  = $clog2(RELEASE_GAP + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SNOOP_WAIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RELEASE_GAP - 1);

    // Handshake: an L1 holds req (read or write) high and treats core_L2_busy
    // as its stall; a beat transfers on every cycle req=1 and core_L2_busy=0.
    arb_state_t        state_q, state_d;
    core_id_t          owner_q, owner_d;
    core_id_t          rr_ptr_q, rr_ptr_d;
    core_id_t          req_core_q, req_core_d;
    logic              op_write_q, op_write_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]        grant0_q, grant0_d;
    logic [7:0]        grant1_q, grant1_d;
    logic [7:0]        flush_q, flush_d;
    logic [7:0]        conflict_q, conflict_d;

    logic [1:0] req;
    core_id_t   pick;
    logic       tenure;
    logic       snoop_on;

    assign req      = core_read_request | core_write_request;
    assign pick     = (&req) ? rr_ptr_q : req[1];
    assign tenure   = is_tenure(state_q);
    assign snoop_on = (state_q == ST_SNOOP_WAIT) || (state_q == ST_FLUSH);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        req_core_d = req_core_q;
        op_write_d = op_write_q;
        tag_d      = tag_q;
        idx_d      = idx_q;
        wait_cnt_d = wait_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        grant0_d   = grant0_q;
        grant1_d   = grant1_q;
        flush_d    = flush_q;
        conflict_d = conflict_q;
        if (!L2_busy) begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        req_core_d = pick;
                        op_write_d = core_write_request[pick];
                        tag_d      = core_word_address[pick][TAG_MSB:TAG_LSB];
                        idx_d      = core_word_address[pick][IDX_MSB:IDX_LSB];
                        wait_cnt_d = '0;
                        if (&req) conflict_d = conflict_q + 8'd1;
                        state_d    = ST_SNOOP_WAIT;
                    end
                end
                ST_SNOOP_WAIT: begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    // A write-back from the snooped core means it holds the block Modified.
                    if (core_write_request[~req_core_q]) begin
                        state_d   = ST_FLUSH;
                        owner_d   = ~req_core_q;
                        gap_cnt_d = '0;
                        flush_d   = flush_q + 8'd1;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_d   = ST_GRANT;
                        owner_d   = req_core_q;
                        gap_cnt_d = '0;
                        if (req_core_q) grant1_d = grant1_q + 8'd1;
                        else            grant0_d = grant0_q + 8'd1;
                    end
                end
                ST_FLUSH: begin
                    if (req[owner_q]) begin
                        gap_cnt_d = '0;
                    end else if (gap_cnt_q == GAP_LAST) begin
                        state_d   = ST_GRANT;
                        owner_d   = req_core_q;
                        gap_cnt_d = '0;
                        if (req_core_q) grant1_d = grant1_q + 8'd1;
                        else            grant0_d = grant0_q + 8'd1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
                ST_GRANT: begin
                    // Tolerates a short req gap between write-back and refill of one miss.
                    if (req[owner_q]) begin
                        gap_cnt_d = '0;
                    end else if (gap_cnt_q == GAP_LAST) begin
                        state_d   = ST_RELEASE;
                        gap_cnt_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
                ST_RELEASE: begin
                    rr_ptr_d = ~owner_q;
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
            req_core_q <= 1'b0;
            op_write_q <= 1'b0;
            tag_q      <= '0;
            idx_q      <= '0;
            wait_cnt_q <= '0;
            gap_cnt_q  <= '0;
            grant0_q   <= '0;
            grant1_q   <= '0;
            flush_q    <= '0;
            conflict_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            req_core_q <= req_core_d;
            op_write_q <= op_write_d;
            tag_q      <= tag_d;
            idx_q      <= idx_d;
            wait_cnt_q <= wait_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            grant0_q   <= grant0_d;
            grant1_q   <= grant1_d;
            flush_q    <= flush_d;
            conflict_q <= conflict_d;
        end
    end

    l2_port_mux #(.N(n)) u_port_mux (
        .sel                (owner_q),
        .force_zero         (~tenure),
        .core_read_request  (core_read_request),
        .core_write_request (core_write_request),
        .core_word_address  (core_word_address),
        .core_write_word    (core_write_word),
        .L2_read_request    (L2_read_request),
        .L2_write_request   (L2_write_request),
        .L2_word_address    (L2_word_address),
        .L2_write_word      (L2_write_word)
    );

    // Snoop goes only to the core that did not start the transaction.
    always_comb begin
        others_read_request  = '0;
        others_write_request = '0;
        others_block_tag     = '0;
        others_block_index   = '0;
        if (snoop_on) begin
            others_read_request[~req_core_q]  = ~op_write_q;
            others_write_request[~req_core_q] = op_write_q;
            others_block_tag[~req_core_q]     = tag_q;
            others_block_index[~req_core_q]   = idx_q;
        end
    end

    assign core_L2_busy[0] = L2_busy | (req[0] & ~(tenure & ~owner_q));
    assign core_L2_busy[1] = L2_busy | (req[1] & ~(tenure & owner_q));

    assign arb_statistics = {grant0_q, grant1_q, flush_q, conflict_q};
    assign dbg_state      = state_q;

endmodule
